enabler_multi: RTL



---
 rtl/enabler_multi_pkg.sv | 17 +
 rtl/enabler_multi_cg.sv | 22 ++
 rtl/enabler_multi.sv | 103 ++++++++++
 3 files changed

// File: rtl/enabler_multi_pkg.sv
// Shared types and helpers for the multi-channel clock enabler.
package enabler_multi_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_ON    = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  // Hold-off counter width, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned idle_cycles);
    int unsigned w;
    w = $clog2(idle_cycles + 32'd1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/enabler_multi_cg.sv
// Clock-gate cell: low-transparent enable latch plus AND, with async reset value.
// Kept as a standalone cell so a library ICG can be swapped in.
module enabler_cg (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rst_val,
  input  logic i_en,
  output logic o_gclk
);

  logic r_en_lat;

  always_latch begin
    if (!i_rst_n)
      r_en_lat <= i_rst_val;
    else if (!i_clk)
      r_en_lat <= i_en;
  end

  assign o_gclk = i_clk & r_en_lat;

endmodule

// File: rtl/enabler_multi.sv
// N-channel clock enabler: per-channel enable FSM with idle hold-off driving
// a glitch-free clock gate; test_en forces every gated clock on.
module enabler_multi
  import enabler_multi_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned IDLE_CYCLES = 2,
  parameter bit          RESET_ON    = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] enb,
  input  logic         test_en,
  output logic [N-1:0] eclk,
  output logic [N-1:0] active,
  output logic         all_off
);

  localparam int unsigned   CW          = cnt_width(IDLE_CYCLES);
  localparam logic [CW-1:0] RELOAD      = (IDLE_CYCLES == 0) ? '0 : CW'(IDLE_CYCLES - 1);
  localparam state_e        RESET_STATE = RESET_ON ? ST_ON : ST_OFF;

  logic [N-1:0] w_act_nxt;
  logic [N-1:0] w_en_req;
  logic [N-1:0] r_active;
  logic         r_all_off;
  logic         w_rst_val;

  assign w_rst_val = RESET_ON | test_en;

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    state_e        r_state;
    state_e        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        ST_OFF: begin
          if (enb[gi])
            w_state_nxt = ST_ON;
        end
        ST_ON: begin
          if (!enb[gi]) begin
            if (IDLE_CYCLES == 0) begin
              w_state_nxt = ST_OFF;
            end else begin
              w_state_nxt = ST_DRAIN;
              w_cnt_nxt   = RELOAD;
            end
          end
        end
        ST_DRAIN: begin
          if (enb[gi])
            w_state_nxt = ST_ON;
          else if (r_cnt == '0)
            w_state_nxt = ST_OFF;
          else
            w_cnt_nxt = r_cnt - CW'(1);
        end
        default: w_state_nxt = ST_OFF;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= RESET_STATE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    assign w_act_nxt[gi] = (w_state_nxt != ST_OFF);
    assign w_en_req[gi]  = (r_state != ST_OFF) | test_en;

    enabler_cg u_cg (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_rst_val (w_rst_val),
      .i_en      (w_en_req[gi]),
      .o_gclk    (eclk[gi])
    );
  end

  // Status flags are taken from next-state so they move on the same edge as the FSMs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= {N{RESET_ON}};
      r_all_off <= !RESET_ON;
    end else begin
      r_active  <= w_act_nxt;
      r_all_off <= ~|w_act_nxt;
    end
  end

  assign active  = r_active;
  assign all_off = r_all_off;

endmodule
